// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, ALUOp classes and funct3 constants
// used by the execute-stage front end.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_PASSB = 4'b0100,
        ALU_SUB   = 4'b0110,
        ALU_EQ    = 4'b0111,
        ALU_NE    = 4'b1000,
        ALU_LT    = 4'b1001,
        ALU_GE    = 4'b1010,
        ALU_LTU   = 4'b1011,
        ALU_GEU   = 4'b1100,
        ALU_SLL   = 4'b1101,
        ALU_SRL   = 4'b1110,
        ALU_SRA   = 4'b1111
    } alu_code_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_e;

    // Arithmetic/logic funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    // The ALU leaves Zero undriven for shifts, so callers must mask it.
    function automatic logic is_shift(input alu_code_e code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Request/result handshake bundle between the issue logic and the execute front end.
interface alu_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_alu_op;
    logic [2:0]            in_funct3;
    logic                  in_funct7b5;
    logic                  in_lui;
    logic [DATA_WIDTH-1:0] in_src_a;
    logic [DATA_WIDTH-1:0] in_src_b;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_zero;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_alu_op, in_funct3, in_funct7b5, in_lui,
               in_src_a, in_src_b, in_tag, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_tag, out_illegal
    );

    modport master (
        output in_valid, in_alu_op, in_funct3, in_funct7b5, in_lui,
               in_src_a, in_src_b, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_tag, out_illegal
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7 decode into the 4-bit ALU operation code.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       lui,
    output alu_code_e  code,
    output logic       illegal
);

    // Decode the instruction class into an ALU code; unknown branches fall back to ADD.
    always_comb begin
        code    = ALU_ADD;
        illegal = 1'b0;
        if (lui) begin
            code = ALU_PASSB;
        end else begin
            case (alu_op_e'(alu_op))
                ALUOP_MEM: code = ALU_ADD;
                ALUOP_BRANCH: begin
                    case (funct3)
                        F3_BEQ:  code = ALU_EQ;
                        F3_BNE:  code = ALU_NE;
                        F3_BLT:  code = ALU_LT;
                        F3_BGE:  code = ALU_GE;
                        F3_BLTU: code = ALU_LTU;
                        F3_BGEU: code = ALU_GEU;
                        default: begin
                            code    = ALU_ADD;
                            illegal = 1'b1;
                        end
                    endcase
                end
                ALUOP_RTYPE, ALUOP_ITYPE: begin
                    case (funct3)
                        // Immediates have no SUB form; bit 30 there is part of the immediate.
                        F3_ADD_SUB: code = ((alu_op_e'(alu_op) == ALUOP_RTYPE) && funct7b5)
                                           ? ALU_SUB : ALU_ADD;
                        F3_SLL:     code = ALU_SLL;
                        F3_SLT:     code = ALU_LT;
                        F3_SLTU:    code = ALU_LTU;
                        F3_XOR:     code = ALU_XOR;
                        F3_SR:      code = funct7b5 ? ALU_SRA : ALU_SRL;
                        F3_OR:      code = ALU_OR;
                        F3_AND:     code = ALU_AND;
                        default:    code = ALU_ADD;
                    endcase
                end
                default: code = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage front end: issue register feeding the external ALU and a result
// register capturing its outputs, with valid/ready on both sides and flush.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int TAG_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    alu_issue_if.slave               bus,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    input  logic                     alu_zero
);

    alu_code_e             dec_code_s;
    logic                  dec_illegal_s;
    logic                  s2_free_s;
    logic                  s1_adv_s;
    logic                  in_ready_s;
    logic                  accept_s;

    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_a_r;
    logic [DATA_WIDTH-1:0] s1_b_r;
    alu_code_e             s1_code_r;
    logic [TAG_WIDTH-1:0]  s1_tag_r;
    logic                  s1_illegal_r;

    logic                  s2_valid_r;
    logic [DATA_WIDTH-1:0] s2_result_r;
    logic                  s2_zero_r;
    logic [TAG_WIDTH-1:0]  s2_tag_r;
    logic                  s2_illegal_r;

    alu_op_decode u_decode (
        .alu_op   (bus.in_alu_op),
        .funct3   (bus.in_funct3),
        .funct7b5 (bus.in_funct7b5),
        .lui      (bus.in_lui),
        .code     (dec_code_s),
        .illegal  (dec_illegal_s)
    );

    // Pipeline advance: a stage moves when the stage ahead is empty or draining.
    always_comb begin
        s2_free_s  = !s2_valid_r || bus.out_ready;
        s1_adv_s   = s1_valid_r && s2_free_s;
        in_ready_s = !s1_valid_r || s2_free_s;
        accept_s   = bus.in_valid && in_ready_s;
    end

    // Issue register: operands and decoded code presented to the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r   <= 1'b0;
            s1_a_r       <= '0;
            s1_b_r       <= '0;
            s1_code_r    <= ALU_ADD;
            s1_tag_r     <= '0;
            s1_illegal_r <= 1'b0;
        end else begin
            if (bus.flush) begin
                s1_valid_r <= 1'b0;
            end else if (accept_s) begin
                s1_valid_r <= 1'b1;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (accept_s && !bus.flush) begin
                s1_a_r       <= bus.in_src_a;
                s1_b_r       <= bus.in_src_b;
                s1_code_r    <= dec_code_s;
                s1_tag_r     <= bus.in_tag;
                s1_illegal_r <= dec_illegal_s;
            end
        end
    end

    // Result register: captures the ALU outputs as the issued op moves on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r   <= 1'b0;
            s2_result_r  <= '0;
            s2_zero_r    <= 1'b0;
            s2_tag_r     <= '0;
            s2_illegal_r <= 1'b0;
        end else begin
            // A flush wins over a same-cycle consume: the output is killed, not delivered.
            if (bus.flush) begin
                s2_valid_r <= 1'b0;
            end else if (s1_adv_s) begin
                s2_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                s2_valid_r <= 1'b0;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
            if (s1_adv_s && !bus.flush) begin
                s2_result_r  <= alu_result;
                s2_zero_r    <= is_shift(s1_code_r) ? 1'b0 : alu_zero;
                s2_tag_r     <= s1_tag_r;
                s2_illegal_r <= s1_illegal_r;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = s2_valid_r;
    assign bus.out_result  = s2_result_r;
    assign bus.out_zero    = s2_zero_r;
    assign bus.out_tag     = s2_tag_r;
    assign bus.out_illegal = s2_illegal_r;

    assign alu_src_a     = s1_a_r;
    assign alu_src_b     = s1_b_r;
    assign alu_operation = OPCODE_LENGTH'(s1_code_r);

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus random traffic
// checked against an instruction-level reference model and an in-order scoreboard.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [3:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_zero;

    alu_issue_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    alu_issue #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .TAG_WIDTH(5)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero)
    );

    always #5 clk = ~clk;

    // Stand-in for the external ALU: compares return the condition on both result
    // and Zero; shifts leave Zero floating high to expose any missing mask.
    always_comb begin
        alu_result = 32'd0;
        alu_zero   = 1'b0;
        case (alu_operation)
            4'b0000: alu_result = alu_src_a & alu_src_b;
            4'b0001: alu_result = alu_src_a | alu_src_b;
            4'b0010: alu_result = alu_src_a + alu_src_b;
            4'b0011: alu_result = alu_src_a ^ alu_src_b;
            4'b0100: alu_result = alu_src_b;
            4'b0110: alu_result = alu_src_a - alu_src_b;
            4'b0111: alu_result = {31'd0, alu_src_a == alu_src_b};
            4'b1000: alu_result = {31'd0, alu_src_a != alu_src_b};
            4'b1001: alu_result = {31'd0, $signed(alu_src_a) < $signed(alu_src_b)};
            4'b1010: alu_result = {31'd0, $signed(alu_src_a) >= $signed(alu_src_b)};
            4'b1011: alu_result = {31'd0, alu_src_a < alu_src_b};
            4'b1100: alu_result = {31'd0, alu_src_a >= alu_src_b};
            4'b1101: alu_result = alu_src_a << alu_src_b[4:0];
            4'b1110: alu_result = alu_src_a >> alu_src_b[4:0];
            4'b1111: alu_result = 32'($signed(alu_src_a) >>> alu_src_b[4:0]);
            default: alu_result = 32'd0;
        endcase
        if (alu_operation >= 4'b0111 && alu_operation <= 4'b1100) alu_zero = alu_result[0];
        else if (alu_operation >= 4'b1101) alu_zero = 1'b1;
        else alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  tag;
        logic        ill;
        int          age;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          delivered = 0;
    logic [31:0] last_result;
    logic        last_zero;
    logic [4:0]  last_tag;
    logic        last_ill;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction semantics, independent of how the DUT encodes them.
    function automatic void ref_exec(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                     input logic lui, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic z, output logic ill);
        logic c;
        c = 1'b0; ill = 1'b0; r = a + b; z = (r == 32'd0);
        if (lui) begin
            r = b; z = (b == 32'd0);
        end else if (op == 2'b01) begin
            case (f3)
                3'd0: c = (a == b);
                3'd1: c = (a != b);
                3'd4: c = ($signed(a) < $signed(b));
                3'd5: c = ($signed(a) >= $signed(b));
                3'd6: c = (a < b);
                3'd7: c = (a >= b);
                default: ill = 1'b1;
            endcase
            if (!ill) begin r = {31'd0, c}; z = c; end
        end else if (op != 2'b00) begin
            case (f3)
                3'd0: begin r = (op == 2'b10 && f7) ? a - b : a + b; z = (r == 32'd0); end
                3'd1: begin r = a << b[4:0]; z = 1'b0; end
                3'd2: begin c = ($signed(a) < $signed(b)); r = {31'd0, c}; z = c; end
                3'd3: begin c = (a < b); r = {31'd0, c}; z = c; end
                3'd4: begin r = a ^ b; z = (r == 32'd0); end
                3'd5: begin r = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0]; z = 1'b0; end
                3'd6: begin r = a | b; z = (r == 32'd0); end
                default: begin r = a & b; z = (r == 32'd0); end
            endcase
        end
    endfunction

    // One clock: sample at negedge+1, update scoreboard, advance to next negedge.
    task automatic cycle(output logic acc);
        exp_t        e;
        logic        exp_ready;
        logic        exp_ov;
        #1;
        exp_ready = !(q.size() == 2 && !bus.out_ready);
        exp_ov    = (q.size() == 2) || (q.size() == 1 && q[0].age >= 2);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        acc = bus.in_valid && exp_ready;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_zero", 32'(bus.out_zero), 32'(e.zero));
                chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
                chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                last_result = bus.out_result; last_zero = bus.out_zero;
                last_tag = bus.out_tag; last_ill = bus.out_illegal;
                delivered++;
            end
            if (acc) begin
                ref_exec(bus.in_alu_op, bus.in_funct3, bus.in_funct7b5, bus.in_lui,
                         bus.in_src_a, bus.in_src_b, e.res, e.zero, e.ill);
                e.tag = bus.in_tag; e.age = 0;
                q.push_back(e);
            end
            foreach (q[i]) q[i].age++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic lui,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus.in_valid = 1'b1; bus.in_alu_op = op; bus.in_funct3 = f3; bus.in_funct7b5 = f7;
        bus.in_lui = lui; bus.in_src_a = a; bus.in_src_b = b; bus.in_tag = tag;
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic lui,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        logic acc;
        acc = 1'b0;
        drive(op, f3, f7, lui, a, b, tag);
        for (int i = 0; i < 20 && !acc; i++) cycle(acc);
        chk("send_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        logic acc;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    // Asynchronous reset asserted between edges; checks the reset-state outputs.
    task automatic do_reset();
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_alu_src_a", alu_src_a, 32'd0);
        chk("rst_alu_src_b", alu_src_b, 32'd0);
        chk("rst_alu_operation", 32'(alu_operation), 32'h2);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic acc;
        int   k;
        int   d0;
        bus.in_valid = 1'b0; bus.in_alu_op = 2'b00; bus.in_funct3 = 3'd0; bus.in_funct7b5 = 1'b0;
        bus.in_lui = 1'b0; bus.in_src_a = 32'd0; bus.in_src_b = 32'd0; bus.in_tag = 5'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // R-type SUB
        send(2'b10, 3'b000, 1'b1, 1'b0, 32'd7, 32'd9, 5'd3);
        drain(3);
        chk("sub_result", last_result, 32'hFFFF_FFFE);
        chk("sub_tag", 32'(last_tag), 32'd3);
        chk("sub_illegal", 32'(last_ill), 32'd0);

        // BGE not taken, then illegal branch funct3
        send(2'b01, 3'b101, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd4);
        drain(3);
        chk("bge_result", last_result, 32'd0);
        chk("bge_zero", 32'(last_zero), 32'd0);
        send(2'b01, 3'b010, 1'b0, 1'b0, 32'd5, 32'd6, 5'd5);
        drain(3);
        chk("illegal_flag", 32'(last_ill), 32'd1);
        chk("illegal_tag", 32'(last_tag), 32'd5);
        chk("illegal_result", last_result, 32'd11);

        // SRA with Zero masked
        send(2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 5'd6);
        drain(3);
        chk("sra_result", last_result, 32'hF800_0000);
        chk("sra_zero", 32'(last_zero), 32'd0);

        // Backpressure: 4 ADDs, output stalled for 5 cycles
        bus.out_ready = 1'b0;
        d0 = delivered;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd100 + 32'(k), 32'd1, 5'(10 + k));
            cycle(acc);
            if (acc) k++;
        end
        chk("bp_accepted_stalled", 32'(k), 32'd2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd100 + 32'(k), 32'd1, 5'(10 + k));
            cycle(acc);
            if (acc) k++;
        end
        drain(4);
        chk("bp_delivered", 32'(delivered - d0), 32'd4);

        // Flush with two ops in flight and a third accepted on the flush cycle
        bus.out_ready = 1'b0;
        send(2'b11, 3'b100, 1'b0, 1'b0, 32'h55, 32'hAA, 5'd20);
        send(2'b11, 3'b110, 1'b0, 1'b0, 32'h0F, 32'hF0, 5'd21);
        d0 = delivered;
        bus.out_ready = 1'b1; bus.flush = 1'b1;
        drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 5'd31);
        cycle(acc);
        bus.flush = 1'b0;
        drain(4);
        chk("flush_delivered", 32'(delivered - d0), 32'd0);

        // Reset mid-stream
        bus.out_ready = 1'b0;
        send(2'b10, 3'b111, 1'b0, 1'b0, 32'hFF, 32'h0F, 5'd7);
        send(2'b10, 3'b001, 1'b0, 1'b0, 32'h1, 32'd3, 5'd8);
        d0 = delivered;
        do_reset();
        bus.out_ready = 1'b1;
        drain(4);
        chk("reset_delivered", 32'(delivered - d0), 32'd0);

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), a, b, 5'($urandom_range(0, 31)));
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            cycle(acc);
        end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drain(4);
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
